// File: rtl/mioc_bus_pkg.sv
// Shared encodings for the Z80-style bus master: command ops, FSM states,
// refresh counter width and the default wait-timeout limit.
package mioc_bus_pkg;

    localparam logic [2:0] OP_MRD  = 3'b000;
    localparam logic [2:0] OP_MWR  = 3'b001;
    localparam logic [2:0] OP_IORD = 3'b010;
    localparam logic [2:0] OP_IOWR = 3'b011;
    localparam logic [2:0] OP_M1   = 3'b100;

    localparam int RFSH_W         = 7;
    localparam int T_WAIT_MAX_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_TWA,
        ST_TW,
        ST_T3,
        ST_T4,
        ST_HOLD
    } bus_state_e;

    function automatic logic op_is_io(input logic [2:0] op);
        return (op == OP_IORD) || (op == OP_IOWR);
    endfunction

    function automatic logic op_is_rsvd(input logic [2:0] op);
        return op > OP_M1;
    endfunction

endpackage

// File: rtl/z80_wait_timer.sv
// Counts consecutive TW cycles that still see WAIT_N low; expired_o flags
// the TW cycle that reaches the configured limit.
module z80_wait_timer #(
    parameter int unsigned MAX = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] LAST = 8'(MAX - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q >= LAST);

endmodule

// File: rtl/z80_bus_master.sv
// Z80-style bus-cycle initiator: turns single-word commands into T-state
// accurate memory, I/O and M1 cycles with refresh, WAIT_N and BUSRQ_N.
module z80_bus_master
    import mioc_bus_pkg::*;
#(
    parameter int unsigned T_WAIT_MAX = T_WAIT_MAX_DEF
) (
    input  logic        B_PHI,
    input  logic        RST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [2:0]  CMD_OP,
    input  logic [15:0] CMD_ADDR,
    input  logic [7:0]  CMD_WDATA,
    output logic        RSP_VALID,
    output logic [7:0]  RSP_RDATA,
    output logic        RSP_TIMEOUT,
    output logic [15:0] BA,
    output logic        BA_OE,
    output logic [7:0]  BD_OUT,
    output logic        BD_OE,
    input  logic [7:0]  BD_IN,
    output logic        BMREQ_N,
    output logic        BIORQ_N,
    output logic        BRD_N,
    output logic        BWR_N,
    output logic        BM1_N,
    output logic        BRFSH_N,
    input  logic        WAIT_N,
    input  logic        BUSRQ_N,
    output logic        BUSAK_N
);

    bus_state_e state_q, state_d;

    logic [2:0]        op_q, op_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [RFSH_W-1:0] rfsh_q, rfsh_d;
    logic              to_q, to_d;

    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_to_q, rsp_to_d;
    logic [15:0] ba_q, ba_d;
    logic        ba_oe_q, ba_oe_d;
    logic [7:0]  bd_out_q, bd_out_d;
    logic        bd_oe_q, bd_oe_d;
    logic        mreq_n_q, mreq_n_d;
    logic        iorq_n_q, iorq_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        m1_n_q, m1_n_d;
    logic        rfsh_n_q, rfsh_n_d;
    logic        busak_n_q, busak_n_d;

    logic accept;
    logic done;
    logic wt_clr;
    logic wt_en;
    logic wt_expired;

    z80_wait_timer #(
        .MAX (T_WAIT_MAX)
    ) u_wait_timer (
        .clk_i     (B_PHI),
        .rst_i     (RST),
        .clr_i     (wt_clr),
        .en_i      (wt_en),
        .expired_o (wt_expired)
    );

    assign wt_clr = (state_q != ST_TW);
    assign wt_en  = (state_q == ST_TW) && !WAIT_N;
    assign accept = CMD_VALID && cmd_ready_q;

    // Next-state and command bookkeeping
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rfsh_d      = rfsh_q;
        to_d        = to_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_to_d    = rsp_to_q;
        done        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = CMD_OP;
                    addr_d  = CMD_ADDR;
                    wdata_d = CMD_WDATA;
                    to_d    = 1'b0;
                    if (op_is_rsvd(CMD_OP)) begin
                        rsp_valid_d = 1'b1;
                        rsp_to_d    = 1'b1;
                    end else begin
                        state_d = ST_T1;
                    end
                end else if (!BUSRQ_N) begin
                    state_d = ST_HOLD;
                end
            end
            ST_T1: state_d = ST_T2;
            ST_T2: begin
                if (op_is_io(op_q)) begin
                    state_d = ST_TWA;
                end else if (!WAIT_N) begin
                    state_d = ST_TW;
                end else begin
                    state_d = ST_T3;
                    if (op_q == OP_M1) rsp_rdata_d = BD_IN;
                end
            end
            ST_TWA: state_d = WAIT_N ? ST_T3 : ST_TW;
            ST_TW: begin
                if (WAIT_N || wt_expired) begin
                    state_d = ST_T3;
                    if (!WAIT_N) to_d = 1'b1;
                    if (op_q == OP_M1) rsp_rdata_d = BD_IN;
                end
            end
            ST_T3: begin
                if (op_q == OP_M1) begin
                    state_d = ST_T4;
                end else begin
                    done = 1'b1;
                    if (op_q == OP_MRD || op_q == OP_IORD) rsp_rdata_d = BD_IN;
                end
            end
            ST_T4: begin
                done   = 1'b1;
                rfsh_d = rfsh_q + 1'b1;
            end
            ST_HOLD: begin
                if (BUSRQ_N) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (done) begin
            rsp_valid_d = 1'b1;
            rsp_to_d    = to_q;
            state_d     = BUSRQ_N ? ST_IDLE : ST_HOLD;
        end
    end

    // Registered bus outputs decoded from the state being entered
    always_comb begin
        logic t1, t2, twa, tw, t3, t4, bus;
        t1  = (state_d == ST_T1);
        t2  = (state_d == ST_T2);
        twa = (state_d == ST_TWA);
        tw  = (state_d == ST_TW);
        t3  = (state_d == ST_T3);
        t4  = (state_d == ST_T4);
        bus = t1 | t2 | twa | tw | t3 | t4;

        cmd_ready_d = (state_d == ST_IDLE) && BUSRQ_N;
        busak_n_d   = (state_d != ST_HOLD);
        ba_oe_d     = (state_d != ST_HOLD);
        ba_d        = ba_q;
        bd_out_d    = bd_out_q;
        bd_oe_d     = 1'b0;
        mreq_n_d    = 1'b1;
        iorq_n_d    = 1'b1;
        rd_n_d      = 1'b1;
        wr_n_d      = 1'b1;
        m1_n_d      = 1'b1;
        rfsh_n_d    = 1'b1;

        if (bus) begin
            ba_d = addr_d;
            unique case (op_d)
                OP_MRD: begin
                    mreq_n_d = 1'b0;
                    rd_n_d   = 1'b0;
                end
                OP_MWR: begin
                    mreq_n_d = 1'b0;
                    wr_n_d   = !(t2 | tw | t3);
                    bd_oe_d  = 1'b1;
                    bd_out_d = wdata_d;
                end
                OP_IORD: begin
                    iorq_n_d = t1;
                    rd_n_d   = t1;
                end
                OP_IOWR: begin
                    iorq_n_d = t1;
                    wr_n_d   = t1;
                    bd_oe_d  = 1'b1;
                    bd_out_d = wdata_d;
                end
                OP_M1: begin
                    m1_n_d   = !(t1 | t2 | tw);
                    rd_n_d   = !(t1 | t2 | tw);
                    mreq_n_d = !(t1 | t2 | tw | t3);
                    rfsh_n_d = !(t3 | t4);
                    if (t3 | t4) ba_d = {9'b0, rfsh_d};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge B_PHI or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MRD;
            addr_q      <= '0;
            wdata_q     <= '0;
            rfsh_q      <= '0;
            to_q        <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_to_q    <= 1'b0;
            ba_q        <= '0;
            ba_oe_q     <= 1'b1;
            bd_out_q    <= '0;
            bd_oe_q     <= 1'b0;
            mreq_n_q    <= 1'b1;
            iorq_n_q    <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            m1_n_q      <= 1'b1;
            rfsh_n_q    <= 1'b1;
            busak_n_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rfsh_q      <= rfsh_d;
            to_q        <= to_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_to_q    <= rsp_to_d;
            ba_q        <= ba_d;
            ba_oe_q     <= ba_oe_d;
            bd_out_q    <= bd_out_d;
            bd_oe_q     <= bd_oe_d;
            mreq_n_q    <= mreq_n_d;
            iorq_n_q    <= iorq_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            m1_n_q      <= m1_n_d;
            rfsh_n_q    <= rfsh_n_d;
            busak_n_q   <= busak_n_d;
        end
    end

    assign CMD_READY   = cmd_ready_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_RDATA   = rsp_rdata_q;
    assign RSP_TIMEOUT = rsp_to_q;
    assign BA          = ba_q;
    assign BA_OE       = ba_oe_q;
    assign BD_OUT      = bd_out_q;
    assign BD_OE       = bd_oe_q;
    assign BMREQ_N     = mreq_n_q;
    assign BIORQ_N     = iorq_n_q;
    assign BRD_N       = rd_n_q;
    assign BWR_N       = wr_n_q;
    assign BM1_N       = m1_n_q;
    assign BRFSH_N     = rfsh_n_q;
    assign BUSAK_N     = busak_n_q;

endmodule

// File: tb/tb_z80_bus_master.sv
// Directed bench for z80_bus_master: per-command strobe/latency checks plus
// a response scoreboard fed at stimulus time and drained on RSP_VALID.
module tb_z80_bus_master;

    logic        B_PHI = 1'b0;
    logic        RST = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [2:0]  CMD_OP = 3'b000;
    logic [15:0] CMD_ADDR = '0;
    logic [7:0]  CMD_WDATA = '0;
    logic        RSP_VALID;
    logic [7:0]  RSP_RDATA;
    logic        RSP_TIMEOUT;
    logic [15:0] BA;
    logic        BA_OE;
    logic [7:0]  BD_OUT;
    logic        BD_OE;
    logic [7:0]  BD_IN = '0;
    logic        BMREQ_N, BIORQ_N, BRD_N, BWR_N, BM1_N, BRFSH_N;
    logic        WAIT_N = 1'b1;
    logic        BUSRQ_N = 1'b1;
    logic        BUSAK_N;

    always #5 B_PHI = ~B_PHI;

    z80_bus_master #(.T_WAIT_MAX(4)) dut (
        .B_PHI(B_PHI), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
        .RSP_TIMEOUT(RSP_TIMEOUT),
        .BA(BA), .BA_OE(BA_OE), .BD_OUT(BD_OUT), .BD_OE(BD_OE),
        .BD_IN(BD_IN),
        .BMREQ_N(BMREQ_N), .BIORQ_N(BIORQ_N), .BRD_N(BRD_N),
        .BWR_N(BWR_N), .BM1_N(BM1_N), .BRFSH_N(BRFSH_N),
        .WAIT_N(WAIT_N), .BUSRQ_N(BUSRQ_N), .BUSAK_N(BUSAK_N)
    );

    typedef struct packed {
        logic [7:0] rdata;
        logic       to;
        logic       chk_d;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    int n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh, n_bdoe, lat;
    logic [15:0] ba_t1;
    logic [7:0]  bdout_t1;
    logic [6:0]  rf_addr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge B_PHI) begin
        if (!RST && RSP_VALID) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL rsp_unexpected: observed RSP_VALID expected none");
            end else begin
                mon_e = sbq.pop_front();
                chk("rsp_timeout", 32'(RSP_TIMEOUT), 32'(mon_e.to));
                if (mon_e.chk_d)
                    chk("rsp_rdata", 32'(RSP_RDATA), 32'(mon_e.rdata));
            end
        end
    end

    // Called at a negedge; returns at the negedge of the RSP_VALID cycle.
    task automatic do_cmd(input logic [2:0] op, input logic [15:0] a,
                          input logic [7:0] wd, input int ws, input int wl,
                          input exp_t e);
        int g;
        g = 0;
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_ADDR  = a;
        CMD_WDATA = wd;
        while (!CMD_READY && g < 50) begin
            @(negedge B_PHI);
            g++;
        end
        if (!CMD_READY) begin
            n_cmp++;
            n_bad++;
            $error("FAIL accept_timeout: observed no CMD_READY expected 1");
            CMD_VALID = 1'b0;
            return;
        end
        sbq.push_back(e);
        @(negedge B_PHI);
        CMD_VALID = 1'b0;
        n_mreq = 0; n_iorq = 0; n_rd = 0; n_wr = 0;
        n_m1 = 0; n_rfsh = 0; n_bdoe = 0; lat = -1;
        for (int k = 1; k <= 60; k++) begin
            if (RSP_VALID) begin
                lat = k;
                break;
            end
            if (k == 1) begin
                ba_t1    = BA;
                bdout_t1 = BD_OUT;
            end
            n_mreq += int'(!BMREQ_N);
            n_iorq += int'(!BIORQ_N);
            n_rd   += int'(!BRD_N);
            n_wr   += int'(!BWR_N);
            n_m1   += int'(!BM1_N);
            n_rfsh += int'(!BRFSH_N);
            n_bdoe += int'(BD_OE);
            if (!BRFSH_N && !BMREQ_N) rf_addr = BA[6:0];
            WAIT_N = !(k >= ws && k < ws + wl);
            @(negedge B_PHI);
        end
        WAIT_N = 1'b1;
    endtask

    initial begin
        exp_t e;
        int   tot_rfsh, tot_m1, max_lat, g;

        repeat (2) @(negedge B_PHI);
        chk("rst_ready", 32'(CMD_READY), 0);
        chk("rst_busak", 32'(BUSAK_N), 1);
        chk("rst_ba", 32'(BA), 0);
        chk("rst_ba_oe", 32'(BA_OE), 1);
        chk("rst_bd_oe", 32'(BD_OE), 0);
        chk("rst_bd_out", 32'(BD_OUT), 0);
        chk("rst_strobes",
            32'({BMREQ_N, BIORQ_N, BRD_N, BWR_N, BM1_N, BRFSH_N}), 32'h3F);
        chk("rst_rsp", 32'({RSP_VALID, RSP_RDATA, RSP_TIMEOUT}), 0);
        RST = 1'b0;
        repeat (2) @(negedge B_PHI);

        // MRD, zero wait
        BD_IN = 8'hA5;
        e = '{rdata: 8'hA5, to: 1'b0, chk_d: 1'b1};
        do_cmd(3'b000, 16'h2000, 8'h00, 0, 0, e);
        chk("mrd_lat", lat, 4);
        chk("mrd_mreq", n_mreq, 3);
        chk("mrd_rd", n_rd, 3);
        chk("mrd_wr", n_wr, 0);
        chk("mrd_ba", 32'(ba_t1), 32'h2000);
        chk("mrd_ready_b2b", 32'(CMD_READY), 1);

        // MWR with two wait states
        e = '{rdata: 8'h00, to: 1'b0, chk_d: 1'b0};
        do_cmd(3'b001, 16'h8001, 8'h3C, 2, 2, e);
        chk("mwr_lat", lat, 6);
        chk("mwr_wr", n_wr, 4);
        chk("mwr_bdoe", n_bdoe, 5);
        chk("mwr_mreq", n_mreq, 5);
        chk("mwr_bdout", 32'(bdout_t1), 32'h3C);

        // IOWR with one extra wait after TWA
        do_cmd(3'b011, 16'h007F, 8'h11, 3, 1, e);
        chk("iowr_lat", lat, 6);
        chk("iowr_iorq", n_iorq, 4);
        chk("iowr_wr", n_wr, 4);
        chk("iowr_mreq", n_mreq, 0);

        // IORD zero wait: only the automatic TWA
        BD_IN = 8'h5A;
        e = '{rdata: 8'h5A, to: 1'b0, chk_d: 1'b1};
        do_cmd(3'b010, 16'h0042, 8'h00, 0, 0, e);
        chk("iord_lat", lat, 5);
        chk("iord_iorq", n_iorq, 3);
        chk("iord_rd", n_rd, 3);

        // WAIT_N stuck low with limit 4
        BD_IN = 8'h77;
        e = '{rdata: 8'h77, to: 1'b1, chk_d: 1'b1};
        do_cmd(3'b000, 16'h1234, 8'h00, 2, 100, e);
        chk("tmo_lat", lat, 8);
        chk("tmo_mreq", n_mreq, 7);

        // Reserved op
        e = '{rdata: 8'h00, to: 1'b1, chk_d: 1'b0};
        do_cmd(3'b110, 16'hFFFF, 8'h00, 0, 0, e);
        chk("rsvd_lat", lat, 1);
        chk("rsvd_strobes", n_mreq + n_iorq + n_rd + n_wr + n_m1, 0);

        // 130 M1 fetches, refresh address wraps
        tot_rfsh = 0;
        tot_m1 = 0;
        max_lat = 0;
        for (int i = 0; i < 130; i++) begin
            BD_IN = 8'(i) ^ 8'h5C;
            e = '{rdata: 8'(i) ^ 8'h5C, to: 1'b0, chk_d: 1'b1};
            do_cmd(3'b100, 16'h4000 + 16'(i), 8'h00, 0, 0, e);
            chk("rfsh_addr", 32'(rf_addr), 32'(i % 128));
            tot_rfsh += n_rfsh;
            tot_m1 += n_m1;
            if (lat > max_lat || lat < 0) max_lat = lat;
        end
        chk("m1_rfsh_total", tot_rfsh, 260);
        chk("m1_m1_total", tot_m1, 260);
        chk("m1_lat", max_lat, 5);

        // BUSRQ_N mid-MRD, then queued MWR
        BD_IN = 8'hC3;
        CMD_VALID = 1'b1;
        CMD_OP = 3'b000;
        CMD_ADDR = 16'h3000;
        sbq.push_back('{rdata: 8'hC3, to: 1'b0, chk_d: 1'b1});
        @(negedge B_PHI);
        CMD_VALID = 1'b0;
        @(negedge B_PHI);
        BUSRQ_N = 1'b0;
        @(negedge B_PHI);
        chk("hold_t3_busak", 32'(BUSAK_N), 1);
        @(negedge B_PHI);
        chk("hold_rsp", 32'(RSP_VALID), 1);
        chk("hold_busak", 32'(BUSAK_N), 0);
        chk("hold_ba_oe", 32'(BA_OE), 0);
        chk("hold_strobes",
            32'({BMREQ_N, BIORQ_N, BRD_N, BWR_N, BM1_N, BRFSH_N}), 32'h3F);
        CMD_VALID = 1'b1;
        CMD_OP = 3'b001;
        CMD_ADDR = 16'h5555;
        CMD_WDATA = 8'h99;
        sbq.push_back('{rdata: 8'h00, to: 1'b0, chk_d: 1'b0});
        repeat (2) @(negedge B_PHI);
        chk("hold_ready", 32'(CMD_READY), 0);
        chk("hold_busak2", 32'(BUSAK_N), 0);
        BUSRQ_N = 1'b1;
        @(negedge B_PHI);
        chk("rel_busak", 32'(BUSAK_N), 1);
        chk("rel_ready", 32'(CMD_READY), 1);
        chk("rel_ba_oe", 32'(BA_OE), 1);
        @(negedge B_PHI);
        CMD_VALID = 1'b0;
        chk("rel_t1_mreq", 32'(BMREQ_N), 0);
        chk("rel_t1_ba", 32'(BA), 32'h5555);
        g = 0;
        while (!RSP_VALID && g < 20) begin
            @(negedge B_PHI);
            g++;
        end
        chk("rel_done", 32'(RSP_VALID), 1);
        @(negedge B_PHI);

        // Reset during T2 of an MRD
        CMD_VALID = 1'b1;
        CMD_OP = 3'b000;
        CMD_ADDR = 16'h0BAD;
        @(negedge B_PHI);
        CMD_VALID = 1'b0;
        @(negedge B_PHI);
        chk("rst_t2_mreq", 32'(BMREQ_N), 0);
        RST = 1'b1;
        #1;
        chk("rst_mid_strobes",
            32'({BMREQ_N, BIORQ_N, BRD_N, BWR_N, BM1_N, BRFSH_N}), 32'h3F);
        chk("rst_mid_ready", 32'(CMD_READY), 0);
        @(negedge B_PHI);
        RST = 1'b0;
        repeat (6) @(negedge B_PHI);

        // Refresh counter restarts after reset
        BD_IN = 8'h21;
        e = '{rdata: 8'h21, to: 1'b0, chk_d: 1'b1};
        do_cmd(3'b100, 16'h0100, 8'h00, 0, 0, e);
        chk("rfsh_after_rst", 32'(rf_addr), 0);
        @(negedge B_PHI);
        chk("sb_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/z80_bus_master.md
# z80_bus_master

Synthesizable Z80-style bus-cycle initiator that drives the buffered CPU-side bus (BA, BD, BMREQ_N, BIORQ_N, BRD_N, BWR_N, BM1_N, BRFSH_N) into mioc_top, and honours WAIT_N and BUSRQ_N/BUSAK_N coming back from it. It turns single-word commands into T-state-accurate memory, I/O, and M1 cycles, with DRAM refresh. It is the initiating end of the bus that mioc_top responds to, and is used for FPGA bring-up and self-checking benches.

## Interface
- T_WAIT_MAX, 255: consecutive TW states before a cycle is force-completed with timeout flagged (1..255).
- B_PHI  in  1  clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY.
- CMD_OP  in  3  000 MRD, 001 MWR, 010 IORD, 011 IOWR, 100 M1 fetch, others reserved.
- CMD_ADDR  in  16  cycle address.
- CMD_WDATA  in  8  write data.
- RSP_VALID  out  1  one-cycle completion pulse.
- RSP_RDATA  out  8  captured read data, valid with RSP_VALID.
- RSP_TIMEOUT  out  1  wait timeout or reserved op, valid with RSP_VALID.
- BA  out  16  bus address.
- BA_OE  out  1  address/strobe drive enable.
- BD_OUT  out  8  write data.
- BD_OE  out  1  data drive enable.
- BD_IN  in  8  read data.
- BMREQ_N, BIORQ_N, BRD_N, BWR_N, BM1_N, BRFSH_N  out  1 each  active-low bus strobes.
- WAIT_N  in  1  active-low wait, synchronous to B_PHI.
- BUSRQ_N  in  1  active-low bus request.
- BUSAK_N  out  1  active-low bus acknowledge.

## Operation
- States: IDLE, T1, T2, TWA (automatic I/O wait), TW, T3, T4, HOLD. Each T-state is one B_PHI cycle. All outputs are registered.
- In IDLE, CMD_READY = BUSRQ_N. On accept, the command is latched and the next state is T1.
- MRD: BMREQ_N=0 and BRD_N=0 during T1–T3. BD_IN is captured on the edge leaving T3.
- MWR: BD_OE=1 with BD_OUT=CMD_WDATA during T1–T3. BMREQ_N=0 during T1–T3. BWR_N=0 during T2–T3.
- IORD/IOWR: BIORQ_N and BRD_N/BWR_N are low during T2, TWA, TW and T3. One TWA is always inserted after T2.
- M1: BM1_N, BMREQ_N and BRD_N are low during T1, T2 and TW. BD_IN is captured on the edge leaving the last of T2/TW.
  - T3 and T4 are refresh: BRFSH_N=0 in both, BMREQ_N=0 in T3 only.
  - During refresh, BA={9'b0, rfsh[6:0]}.
  - The 7-bit rfsh counter increments modulo 128 leaving T4.
- WAIT_N is sampled on the edge leaving T2 (TWA for I/O). If low, go to TW, and stay in TW while WAIT_N=0. Strobes hold their values through TW.
- Timeout: if T_WAIT_MAX consecutive TW cycles see WAIT_N=0, go to T3 anyway and set RSP_TIMEOUT=1. Read data is still captured.
- Reserved op: no bus activity. RSP_VALID=1 and RSP_TIMEOUT=1 in the cycle after accept.
- BUSRQ_N is sampled in IDLE and on the edge leaving the final T-state (T3, or T4 for M1).
  - If low, go to HOLD: BA_OE=0, BD_OE=0, all strobes 1. BUSAK_N=0 from the first HOLD cycle.
  - The bus is released on the first edge with BUSRQ_N=1: BUSAK_N=1 and return to IDLE.
  - BUSRQ_N takes priority over a pending CMD_VALID.
- Reset values: all strobes 1, BUSAK_N=1, BA=0, BA_OE=1, BD_OE=0, BD_OUT=0, CMD_READY=0 while RST=1, RSP_VALID=0, RSP_RDATA=0, RSP_TIMEOUT=0, rfsh=0, state IDLE.
- Reset mid-cycle aborts immediately with no RSP_VALID.

## Timing
- The edge that accepts a command enters T1, so strobes and BA are visible in the next cycle.
- Zero-wait latency from accept edge to RSP_VALID cycle:
  - MRD/MWR: 4 cycles.
  - IORD/IOWR: 5 cycles.
  - M1: 5 cycles.
- Each TW cycle adds one cycle.
- RSP_VALID is high in the cycle after the final T-state, which is also the first IDLE (or HOLD) cycle. A new command can be accepted in that same cycle, giving back-to-back cycles with one IDLE between them.
- BUSAK_N falls one cycle after BUSRQ_N is sampled low, and rises on the edge that samples BUSRQ_N high.

## Structure
- Package mioc_bus_pkg holds:
  - CMD_OP encodings.
  - The state enum.
  - The refresh counter width (7).
  - The default T_WAIT_MAX.
- Sub-module z80_wait_timer: 8-bit consecutive-wait counter with clear/enable inputs and an expired output, instantiated once.

## Test plan
- MRD at 0x2000 with BD_IN=0xA5 and WAIT_N=1 → BMREQ_N/BRD_N low for exactly 3 cycles; RSP_VALID 4 cycles after accept with RSP_RDATA=0xA5 and RSP_TIMEOUT=0.
- MWR at 0x8001 with data 0x3C and WAIT_N held low for 2 cycles after T2 → BWR_N low for 4 cycles; BD_OUT=0x3C with BD_OE=1 for 5 cycles; RSP_VALID 6 cycles after accept.
- IOWR at port 0x7F → BIORQ_N low for 4 cycles including the automatic wait; BMREQ_N stays 1.
- 130 consecutive M1 fetches → BRFSH_N low for 2 cycles each; refresh address BA[6:0] runs 0..127 then wraps to 0,1.
- WAIT_N stuck low with T_WAIT_MAX=4 → exactly 4 TW cycles, then RSP_TIMEOUT=1.
- BUSRQ_N driven low mid-MRD → the cycle completes, then BUSAK_N=0 with BA_OE=0; BUSRQ_N high → BUSAK_N=1 on the next edge and the queued command starts. Asserting RST during T2 → all strobes 1 immediately and no RSP_VALID.
